// File: rtl/a_cmp_b_seq.sv
// Bit-serial MSB-first magnitude comparator with valid/ready on both sides.
// Define CMP_SIGNED_EN for two's complement operands.
module a_cmp_b_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             bit_a;
  logic             bit_b;
  logic             d_lt;
  logic             d_gt;

  assign bit_a = a_r[idx];
  assign bit_b = b_r[idx];

  // Sign bit inverts the decision when the operands differ there.
  always_comb begin
    d_gt = bit_a;
    d_lt = bit_b;
`ifdef CMP_SIGNED_EN
    if (idx == IDX_MAX) begin
      d_gt = bit_b;
      d_lt = bit_a;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= IDX_MAX;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            idx      <= IDX_MAX;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          unique case (1'b1)
            (bit_a != bit_b): begin
              lt        <= d_lt;
              gt        <= d_gt;
              eq        <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
            (bit_a == bit_b) && (idx == '0): begin
              lt        <= 1'b0;
              gt        <= 1'b0;
              eq        <= 1'b1;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
            default: idx <= idx - 1'b1;
          endcase
        end
        HOLD: begin
          if (out_ready) begin
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
